// File: rtl/stall_ctrl_if.sv
// Pipeline-side bundle of stall/flush requests and the controller's hold/flush outputs.
interface stall_ctrl_if;
  logic        stallreq_if;
  logic        stallreq_id;
  logic        stallreq_ex;
  logic        flush_req;
  logic [5:0]  stall_o;
  logic        flush_o;
  logic        timeout_o;
  logic [31:0] stall_cnt_o;

  modport master (
    output stallreq_if, stallreq_id, stallreq_ex, flush_req,
    input  stall_o, flush_o, timeout_o, stall_cnt_o
  );

  modport slave (
    input  stallreq_if, stallreq_id, stallreq_ex, flush_req,
    output stall_o, flush_o, timeout_o, stall_cnt_o
  );
endinterface

// File: rtl/stall_ctrl.sv
// Pipeline stall/flush controller with EX-stall watchdog.
// Optional stall-cycle performance counter enabled by defining STALL_CNT_EN.
module stall_ctrl #(
  parameter int unsigned EX_TIMEOUT   = 64,
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic         clk,
  input  logic         rst,
  stall_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {RUN, HOLD_EX, FLUSH} state_e;

  localparam logic [7:0] EX_LAST = 8'(EX_TIMEOUT - 1);
  localparam logic [2:0] FL_LOAD = 3'(FLUSH_CYCLES - 1);

  state_e     state_q, state_d;
  logic [7:0] ex_cnt_q, ex_cnt_d;
  logic [2:0] fl_cnt_q, fl_cnt_d;
  logic [5:0] stall_req;
  logic       timeout_hit;

  always_comb begin
    if (bus.stallreq_ex)      stall_req = 6'b001111;
    else if (bus.stallreq_id) stall_req = 6'b000111;
    else if (bus.stallreq_if) stall_req = 6'b000011;
    else                      stall_req = 6'b000000;
  end

  // NOTE: every output of this block gets a default first, so no path leaves a latch.
  always_comb begin
    state_d     = state_q;
    ex_cnt_d    = ex_cnt_q;
    fl_cnt_d    = fl_cnt_q;
    timeout_hit = 1'b0;
    case (state_q)
      RUN: begin
        if (bus.flush_req) begin
          state_d  = FLUSH;
          fl_cnt_d = FL_LOAD;
          ex_cnt_d = 8'd0;
        end else if (bus.stallreq_ex) begin
          state_d  = HOLD_EX;
          ex_cnt_d = 8'd1;
        end
      end
      HOLD_EX: begin
        if (bus.flush_req) begin
          state_d  = FLUSH;
          fl_cnt_d = FL_LOAD;
          ex_cnt_d = 8'd0;
        end else if (!bus.stallreq_ex) begin
          state_d  = RUN;
          ex_cnt_d = 8'd0;
        end else if (ex_cnt_q == EX_LAST) begin
          timeout_hit = 1'b1;
          state_d     = FLUSH;
          fl_cnt_d    = FL_LOAD;
          ex_cnt_d    = 8'd0;
        end else begin
          ex_cnt_d = ex_cnt_q + 8'd1;
        end
      end
      FLUSH: begin
        // A new flush request restarts the hold window instead of stacking.
        if (bus.flush_req)          fl_cnt_d = FL_LOAD;
        else if (fl_cnt_q == 3'd0)  state_d  = RUN;
        else                        fl_cnt_d = fl_cnt_q - 3'd1;
      end
      default: state_d = RUN;
    endcase
  end

  // NOTE: state uses non-blocking assignments under an async active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= RUN;
      ex_cnt_q <= 8'd0;
      fl_cnt_q <= 3'd0;
    end else begin
      state_q  <= state_d;
      ex_cnt_q <= ex_cnt_d;
      fl_cnt_q <= fl_cnt_d;
    end
  end

  // Stall decode is combinational so requests see no added latency; reset masks it.
  assign bus.stall_o   = (rst && state_q != FLUSH) ? stall_req : 6'b000000;
  assign bus.flush_o   = rst && (state_q == FLUSH);
  assign bus.timeout_o = rst && timeout_hit;

`ifdef STALL_CNT_EN
  logic [31:0] stall_cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      stall_cnt_q <= 32'd0;
    else if (bus.stall_o[0] && stall_cnt_q != 32'hFFFF_FFFF)
      stall_cnt_q <= stall_cnt_q + 32'd1;
  end

  assign bus.stall_cnt_o = stall_cnt_q;
`else
  assign bus.stall_cnt_o = 32'h0;
`endif

endmodule

// File: tb/tb_stall_ctrl.sv
// Self-checking bench for stall_ctrl: directed literal sequences plus randomized
// traffic compared every cycle against a streak/remaining-cycles reference model.
module tb_stall_ctrl;
  localparam int unsigned EX_TO = 4;
  localparam int unsigned FC    = 2;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  stall_ctrl_if bus ();

  stall_ctrl #(.EX_TIMEOUT(EX_TO), .FLUSH_CYCLES(FC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input logic r, input logic i_if, input logic i_id,
                      input logic i_ex, input logic i_fl);
    @(posedge clk);
    #1;
    rst             = r;
    bus.stallreq_if = i_if;
    bus.stallreq_id = i_id;
    bus.stallreq_ex = i_ex;
    bus.flush_req   = i_fl;
  endtask

  task automatic expect_out(input string name, input logic [5:0] s,
                            input logic f, input logic t);
    @(negedge clk);
    check({name, " stall"},   32'(bus.stall_o),   32'(s));
    check({name, " flush"},   32'(bus.flush_o),   32'(f));
    check({name, " timeout"}, 32'(bus.timeout_o), 32'(t));
  endtask

  // Reference model: tracks the length of the current EX-stall streak and the
  // number of flush cycles still owed; outputs follow directly from those.
  int unsigned m_streak = 0;
  int unsigned m_left   = 0;
  logic [31:0] m_cnt    = 32'd0;

  always @(negedge clk) begin : model
    logic [5:0]  e_stall;
    logic        e_fl, e_to;
    logic [31:0] e_cnt;
    int unsigned streak_now;
    if (!rst) begin
      check("model rst stall", 32'(bus.stall_o), 32'd0);
      check("model rst flush", 32'(bus.flush_o), 32'd0);
      check("model rst tmo",   32'(bus.timeout_o), 32'd0);
      check("model rst cnt",   bus.stall_cnt_o, 32'd0);
      m_streak = 0;
      m_left   = 0;
      m_cnt    = 32'd0;
    end else begin
      e_stall    = 6'b000000;
      e_to       = 1'b0;
      e_fl       = (m_left != 0);
      streak_now = 0;
      if (!e_fl) begin
        if (bus.stallreq_ex)      e_stall = 6'b001111;
        else if (bus.stallreq_id) e_stall = 6'b000111;
        else if (bus.stallreq_if) e_stall = 6'b000011;
        streak_now = bus.stallreq_ex ? m_streak + 1 : 0;
        e_to = bus.stallreq_ex && !bus.flush_req && (streak_now == EX_TO);
      end
`ifdef STALL_CNT_EN
      e_cnt = m_cnt;
`else
      e_cnt = 32'd0;
`endif
      check("model stall", 32'(bus.stall_o),   32'(e_stall));
      check("model flush", 32'(bus.flush_o),   32'(e_fl));
      check("model tmo",   32'(bus.timeout_o), 32'(e_to));
      check("model cnt",   bus.stall_cnt_o,    e_cnt);
      if (e_stall[0] && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 32'd1;
      if (e_fl) begin
        m_left   = bus.flush_req ? FC : m_left - 1;
        m_streak = 0;
      end else if (bus.flush_req || e_to) begin
        m_left   = FC;
        m_streak = 0;
      end else begin
        m_streak = streak_now;
      end
    end
  end

  initial begin
    logic r_ex;
    rst             = 1'b0;
    bus.stallreq_if = 1'b1;
    bus.stallreq_id = 1'b1;
    bus.stallreq_ex = 1'b1;
    bus.flush_req   = 1'b1;
    #1;
    check("reset stall forced 0", 32'(bus.stall_o), 32'd0);
    check("reset flush",          32'(bus.flush_o), 32'd0);
    check("reset timeout",        32'(bus.timeout_o), 32'd0);
    check("reset cnt",            bus.stall_cnt_o, 32'd0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    expect_out("idle", 6'b000000, 1'b0, 1'b0);

    // Seven IF-stall cycles feed the performance counter.
    for (int i = 0; i < 7; i++) begin
      step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      expect_out("if stall", 6'b000011, 1'b0, 1'b0);
    end
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    expect_out("after if", 6'b000000, 1'b0, 1'b0);
`ifdef STALL_CNT_EN
    check("stall cnt 7", bus.stall_cnt_o, 32'd7);
`else
    check("stall cnt tied 0", bus.stall_cnt_o, 32'd0);
`endif

    // Load-use hazard in RUN.
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
      expect_out("id stall", 6'b000111, 1'b0, 1'b0);
    end

    // EX beats ID; a short streak ends cleanly and the next one starts from zero.
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 3; i++) begin
        step(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        expect_out("ex+id stall", 6'b001111, 1'b0, 1'b0);
      end
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      expect_out("ex release", 6'b000000, 1'b0, 1'b0);
    end

    // Watchdog: fires on the 4th stall cycle, then two flush cycles.
    for (int i = 1; i <= 4; i++) begin
      step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
      expect_out("ex hold", 6'b001111, 1'b0, (i == 4));
    end
    for (int i = 0; i < 2; i++) begin
      step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
      expect_out("timeout flush", 6'b000000, 1'b1, 1'b0);
    end
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    expect_out("ex after flush", 6'b001111, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    expect_out("idle2", 6'b000000, 1'b0, 1'b0);

    // flush_req on the would-be timeout cycle wins; no pulse.
    for (int i = 1; i <= 4; i++) begin
      step(1'b1, 1'b0, 1'b0, 1'b1, (i == 4));
      expect_out("ex pre-flush", 6'b001111, 1'b0, 1'b0);
    end
    for (int i = 0; i < 2; i++) begin
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      expect_out("req flush", 6'b000000, 1'b1, 1'b0);
    end

    // Flush from HOLD_EX, extended by a second request on its first cycle.
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    expect_out("hold entry", 6'b001111, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    expect_out("flush req cycle", 6'b001111, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    expect_out("flush ext 1", 6'b000000, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    expect_out("flush ext 2", 6'b000000, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    expect_out("flush ext 3", 6'b000000, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    expect_out("run after ext", 6'b001111, 1'b0, 1'b0);

    // Reset in the middle of a flush.
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    expect_out("pre-rst req", 6'b000000, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    expect_out("pre-rst flush", 6'b000000, 1'b1, 1'b0);
    #2;
    rst = 1'b0;
    #1;
    check("mid-flush rst flush", 32'(bus.flush_o), 32'd0);
    check("mid-flush rst stall", 32'(bus.stall_o), 32'd0);
    check("mid-flush rst cnt",   bus.stall_cnt_o, 32'd0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      expect_out("post-rst quiet", 6'b000000, 1'b0, 1'b0);
    end
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    expect_out("post-rst ex", 6'b001111, 1'b0, 1'b0);

    // Randomized traffic with sticky EX requests and rare resets.
    r_ex = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      r_ex = r_ex ? ($urandom_range(0, 99) < 85) : ($urandom_range(0, 99) < 20);
      step(($urandom_range(0, 399) != 0),
           ($urandom_range(0, 2) == 0),
           ($urandom_range(0, 3) == 0),
           r_ex,
           ($urandom_range(0, 14) == 0));
    end
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
